// File: rtl/dehaze_frame_sequencer.sv
// Two-pass frame sequencer: streams a stored BGR frame into the haze-removal pipeline,
// first for atmospheric-light estimation, then with te_enable for scene recovery.
module dehaze_frame_sequencer #(
  parameter int ADDR_W     = 19,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1048575
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] num_pixels,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rd_data,
  output logic [23:0]       pix_out,
  output logic              pix_valid,
  output logic              te_enable,
  input  logic              ale_done,
  input  logic              res_valid,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_we,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0]   TO_LIM   = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
  localparam logic [3:0]        GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS1,
    S_WAIT_ALE,
    S_GAP,
    S_PASS2,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_num;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic [ADDR_W-1:0] r_res_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [3:0]        r_gap_cnt;
  logic              r_pix_valid;
  logic              r_te;
  logic              r_timeout;

  logic              w_rd_en;
  logic              w_rd_last;
  logic              w_res_active;
  logic              w_res_we;
  logic [ADDR_W-1:0] w_res_cnt_nxt;
  logic              w_to_fire;
  logic              w_start_acc;
  logic              w_set_timeout;
  logic              w_state_chg;

  assign w_rd_en       = (r_state == S_PASS1) || (r_state == S_PASS2);
  assign w_rd_last     = (r_rd_cnt == (r_num - A_ONE));
  assign w_res_active  = (r_state == S_GAP) || (r_state == S_PASS2) || (r_state == S_DRAIN);
  assign w_res_we      = res_valid && w_res_active && (r_res_cnt < r_num);
  assign w_res_cnt_nxt = w_res_we ? (r_res_cnt + A_ONE) : r_res_cnt;
  assign w_to_fire     = (TIMEOUT != 0) && (r_to_cnt == TO_LIM);
  assign w_start_acc   = (r_state == S_IDLE) && start && !abort;
  assign w_state_chg   = (w_state_nxt != r_state);

  always_comb begin
    w_state_nxt   = r_state;
    w_set_timeout = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) w_state_nxt = (num_pixels == '0) ? S_DONE : S_PASS1;
        end
        S_PASS1: begin
          if (w_rd_last) w_state_nxt = S_WAIT_ALE;
        end
        S_WAIT_ALE: begin
          // the last pass-1 pixel is already on the bus in the first WAIT_ALE cycle
          if (ale_done) begin
            w_state_nxt = S_GAP;
          end else if (w_to_fire) begin
            w_state_nxt   = S_DONE;
            w_set_timeout = 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) w_state_nxt = S_PASS2;
        end
        S_PASS2: begin
          if (w_rd_last) w_state_nxt = S_DRAIN;
        end
        S_DRAIN: begin
          if (w_res_cnt_nxt == r_num) begin
            w_state_nxt = S_DONE;
          end else if (w_to_fire) begin
            w_state_nxt   = S_DONE;
            w_set_timeout = 1'b1;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_rd_cnt    <= '0;
      r_res_cnt   <= '0;
      r_to_cnt    <= '0;
      r_gap_cnt   <= '0;
      r_pix_valid <= 1'b0;
      r_te        <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pix_valid <= w_rd_en && !abort;

      if (w_start_acc) r_num <= num_pixels;

      if (w_state_chg)  r_rd_cnt <= '0;
      else if (w_rd_en) r_rd_cnt <= r_rd_cnt + A_ONE;

      if (w_state_nxt == S_IDLE) r_res_cnt <= '0;
      else                       r_res_cnt <= w_res_cnt_nxt;

      if (w_state_chg) r_to_cnt <= '0;
      else if ((r_state == S_WAIT_ALE) || (r_state == S_DRAIN)) r_to_cnt <= r_to_cnt + TO_ONE;

      if (w_state_chg)             r_gap_cnt <= '0;
      else if (r_state == S_GAP)   r_gap_cnt <= r_gap_cnt + 4'd1;

      if (w_state_nxt == S_IDLE)     r_te <= 1'b0;
      else if (w_state_nxt == S_GAP) r_te <= 1'b1;

      if (w_start_acc)        r_timeout <= 1'b0;
      else if (w_set_timeout) r_timeout <= 1'b1;
    end
  end

  assign mem_rd_en = w_rd_en;
  assign mem_addr  = w_rd_en ? r_rd_cnt : '0;
  assign pix_valid = r_pix_valid;
  assign pix_out   = r_pix_valid ? mem_rd_data : 24'd0;
  assign te_enable = r_te;
  assign res_we    = w_res_we;
  assign res_addr  = r_res_cnt;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign timeout   = r_timeout;

endmodule
